// File: rtl/lanectrl_pause_pkg.sv
// lanectrl_pause_pkg: shared states, default timing and timer sizing for the clock-pause initiator
package lanectrl_pause_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, LOAD, HOLD, RELEASE, ACK, WAIT_LOW} pause_state_t;

    localparam int DEF_PRE_CYCLES  = 4;
    localparam int DEF_HOLD_CYCLES = 2;
    localparam int DEF_POST_CYCLES = 4;
    localparam int MIN_PRE_CYCLES  = 3;
    localparam int MIN_HOLD_CYCLES = 1;
    localparam int MIN_POST_CYCLES = 1;

    // Timer must hold the largest reload value (count-1); never narrower than one bit.
    function automatic int timer_width(input int pre, input int hold, input int post);
        int m;
        m = (pre > hold) ? pre : hold;
        m = (m > post) ? m : post;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/lanectrl_pause_timer.sv
// lanectrl_pause_timer: loadable down-counter with zero flag, shared by all timed phases
module lanectrl_pause_timer #(
    parameter int W = 2
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    assign zero = (cnt == '0);

    // Reload wins over decrement; the counter idles at whatever value it last reached.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - W'(1);
    end

endmodule

// File: rtl/lanectrl_pause_gen.sv
// lanectrl_pause_gen: pauses the HS_IO clock, loads a new delay code, releases and acknowledges
module lanectrl_pause_gen
    import lanectrl_pause_pkg::*;
#(
    parameter int CODE_W      = 8,
    parameter int PRE_CYCLES  = DEF_PRE_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int POST_CYCLES = DEF_POST_CYCLES
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              UPDATE_REQ,
    input  logic [CODE_W-1:0] CODE_IN,
    output logic              UPDATE_ACK,
    output logic              BUSY,
    output logic              HS_IO_CLK_PAUSE,
    output logic              DLY_LOAD,
    output logic [CODE_W-1:0] DLY_CODE
);

    localparam int TW = timer_width(PRE_CYCLES, HOLD_CYCLES, POST_CYCLES);
    localparam logic [TW-1:0] PRE_V  = TW'(PRE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_V = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] POST_V = TW'(POST_CYCLES - 1);

    if (PRE_CYCLES < MIN_PRE_CYCLES) begin : g_pre_chk
        $error("PRE_CYCLES must be at least %0d", MIN_PRE_CYCLES);
    end
    if (HOLD_CYCLES < MIN_HOLD_CYCLES) begin : g_hold_chk
        $error("HOLD_CYCLES must be at least %0d", MIN_HOLD_CYCLES);
    end
    if (POST_CYCLES < MIN_POST_CYCLES) begin : g_post_chk
        $error("POST_CYCLES must be at least %0d", MIN_POST_CYCLES);
    end

    pause_state_t      state, state_n;
    logic              ack_n, busy_n, pause_n, load_n;
    logic [CODE_W-1:0] code_n, shadow, shadow_n;
    logic              t_load, t_dec, t_zero;
    logic [TW-1:0]     t_val;

    lanectrl_pause_timer #(.W(TW)) u_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    // Next state, next registered outputs and timer control.
    always_comb begin
        state_n  = state;
        ack_n    = 1'b0;
        load_n   = 1'b0;
        busy_n   = BUSY;
        pause_n  = HS_IO_CLK_PAUSE;
        code_n   = DLY_CODE;
        shadow_n = shadow;
        t_load   = 1'b0;
        t_dec    = 1'b0;
        t_val    = '0;
        case (state)
            IDLE: if (UPDATE_REQ) begin
                shadow_n = CODE_IN;
                pause_n  = 1'b1;
                busy_n   = 1'b1;
                t_load   = 1'b1;
                t_val    = PRE_V;
                state_n  = SETUP;
            end
            SETUP: if (t_zero) begin
                code_n  = shadow;
                load_n  = 1'b1;
                state_n = LOAD;
            end else t_dec = 1'b1;
            LOAD: begin
                t_load  = 1'b1;
                t_val   = HOLD_V;
                state_n = HOLD;
            end
            HOLD: if (t_zero) begin
                pause_n = 1'b0;
                t_load  = 1'b1;
                t_val   = POST_V;
                state_n = RELEASE;
            end else t_dec = 1'b1;
            RELEASE: if (t_zero) begin
                ack_n   = 1'b1;
                state_n = ACK;
            end else t_dec = 1'b1;
            ACK: state_n = WAIT_LOW;
            WAIT_LOW: if (!UPDATE_REQ) begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and all outputs are registered; reset aborts any pause immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state           <= IDLE;
            UPDATE_ACK      <= 1'b0;
            BUSY            <= 1'b0;
            HS_IO_CLK_PAUSE <= 1'b0;
            DLY_LOAD        <= 1'b0;
            DLY_CODE        <= '0;
            shadow          <= '0;
        end else begin
            state           <= state_n;
            UPDATE_ACK      <= ack_n;
            BUSY            <= busy_n;
            HS_IO_CLK_PAUSE <= pause_n;
            DLY_LOAD        <= load_n;
            DLY_CODE        <= code_n;
            shadow          <= shadow_n;
        end
    end

endmodule

// File: tb/tb_lanectrl_pause_gen.sv
// tb_lanectrl_pause_gen: default and minimum-timing instances checked against a cycle-offset model
module tb_lanectrl_pause_gen;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       req = 1'b0;
    logic [7:0] code_in = 8'h00;

    logic       ack [2];
    logic       busy [2];
    logic       pause [2];
    logic       load [2];
    logic [7:0] code [2];

    int pre_p  [2] = '{4, 3};
    int hold_p [2] = '{2, 1};
    int post_p [2] = '{4, 1};

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    lanectrl_pause_gen #(.CODE_W(8), .PRE_CYCLES(4), .HOLD_CYCLES(2), .POST_CYCLES(4)) dut0 (
        .CLK(CLK), .RESET(RESET), .UPDATE_REQ(req), .CODE_IN(code_in),
        .UPDATE_ACK(ack[0]), .BUSY(busy[0]), .HS_IO_CLK_PAUSE(pause[0]),
        .DLY_LOAD(load[0]), .DLY_CODE(code[0])
    );

    lanectrl_pause_gen #(.CODE_W(8), .PRE_CYCLES(3), .HOLD_CYCLES(1), .POST_CYCLES(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .UPDATE_REQ(req), .CODE_IN(code_in),
        .UPDATE_ACK(ack[1]), .BUSY(busy[1]), .HS_IO_CLK_PAUSE(pause[1]),
        .DLY_LOAD(load[1]), .DLY_CODE(code[1])
    );

    // Model: a transaction is just "cycles since accept" k; every output is a window on k.
    logic       m_act [2];
    int         m_k [2];
    logic [7:0] m_sh [2];
    logic [7:0] m_code [2];

    function automatic int ack_at(input int i);
        return pre_p[i] + 1 + hold_p[i] + post_p[i];
    endfunction

    always @(posedge CLK or posedge RESET) begin
        for (int i = 0; i < 2; i++) begin
            if (RESET) begin
                m_act[i]  <= 1'b0;
                m_k[i]    <= 0;
                m_code[i] <= 8'h00;
            end else if (!m_act[i]) begin
                if (req) begin
                    m_act[i] <= 1'b1;
                    m_k[i]   <= 0;
                    m_sh[i]  <= code_in;
                end
            end else begin
                m_k[i] <= m_k[i] + 1;
                if (m_k[i] + 1 == pre_p[i]) m_code[i] <= m_sh[i];
                if (m_k[i] + 1 >= ack_at(i) + 2 && !req) m_act[i] <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", nm, i, $time, a, e);
        end
    endtask

    always @(posedge CLK) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("busy",  i, 32'(busy[i]),  32'(m_act[i]));
            chk("pause", i, 32'(pause[i]), 32'(m_act[i] && m_k[i] < pre_p[i] + 1 + hold_p[i]));
            chk("load",  i, 32'(load[i]),  32'(m_act[i] && m_k[i] == pre_p[i]));
            chk("ack",   i, 32'(ack[i]),   32'(m_act[i] && m_k[i] == ack_at(i)));
            chk("code",  i, 32'(code[i]),  32'(m_code[i]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        step(3);
        chk("rst_pause", 0, 32'(pause[0]), 0);
        chk("rst_busy",  0, 32'(busy[0]), 0);
        chk("rst_code",  0, 32'(code[0]), 0);
        RESET = 1'b0;
        step(2);

        // Single update, code changes after accept, REQ dropped at ACK.
        req = 1'b1; code_in = 8'h5A;
        for (int k = 0; k <= 13; k++) begin
            step(1);
            if (k == 0)  chk("t1_pause_rise", 0, 32'(pause[0]), 1);
            if (k == 2)  code_in = 8'h33;
            if (k == 3)  chk("t1_load_k3", 0, 32'(load[0]), 0);
            if (k == 4)  begin chk("t1_load_k4", 0, 32'(load[0]), 1); chk("t1_code_k4", 0, 32'(code[0]), 32'h5A); end
            if (k == 4)  chk("t1_small_pause_k4", 1, 32'(pause[1]), 1);
            if (k == 5)  begin chk("t1_load_k5", 0, 32'(load[0]), 0); chk("t1_small_pause_k5", 1, 32'(pause[1]), 0); end
            if (k == 6)  begin chk("t1_pause_k6", 0, 32'(pause[0]), 1); chk("t1_small_ack_k6", 1, 32'(ack[1]), 1); end
            if (k == 7)  chk("t1_pause_k7", 0, 32'(pause[0]), 0);
            if (k == 10) chk("t1_ack_k10", 0, 32'(ack[0]), 0);
            if (k == 11) begin chk("t1_ack_k11", 0, 32'(ack[0]), 1); req = 1'b0; end
            if (k == 12) begin chk("t1_ack_k12", 0, 32'(ack[0]), 0); chk("t1_busy_k12", 0, 32'(busy[0]), 1); end
            if (k == 13) begin chk("t1_busy_k13", 0, 32'(busy[0]), 0); chk("t1_code_hold", 0, 32'(code[0]), 32'h5A); end
        end
        step(2);

        // REQ dropped early: sequence still completes.
        req = 1'b1; code_in = 8'hC3;
        for (int k = 0; k <= 13; k++) begin
            step(1);
            if (k == 3)  req = 1'b0;
            if (k == 11) chk("t2_ack_k11", 0, 32'(ack[0]), 1);
            if (k == 12) chk("t2_busy_k12", 0, 32'(busy[0]), 1);
            if (k == 13) chk("t2_busy_k13", 0, 32'(busy[0]), 0);
        end
        step(2);

        // REQ held long past ACK: no second pause.
        req = 1'b1;
        for (int k = 0; k <= 31; k++) begin
            step(1);
            if (k == 20) chk("t3_no_repause", 0, 32'(pause[0]), 0);
            if (k == 31) chk("t3_still_busy", 0, 32'(busy[0]), 1);
        end
        req = 1'b0;
        step(3);

        // Reset mid-HOLD aborts with no ACK; next request runs clean.
        req = 1'b1; code_in = 8'h77;
        step(6);
        RESET = 1'b1; req = 1'b0;
        #1;
        chk("t4_pause_async", 0, 32'(pause[0]), 0);
        chk("t4_busy_async",  0, 32'(busy[0]), 0);
        chk("t4_code_async",  0, 32'(code[0]), 0);
        step(2);
        RESET = 1'b0;
        step(2);
        req = 1'b1; code_in = 8'h10;
        for (int k = 0; k <= 11; k++) begin
            step(1);
            if (k == 4)  chk("t4_code_k4", 0, 32'(code[0]), 32'h10);
            if (k == 11) begin chk("t4_ack_k11", 0, 32'(ack[0]), 1); req = 1'b0; end
        end
        step(4);

        // Random REQ/CODE traffic with rare resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) req = ~req;
            code_in = 8'($urandom);
            RESET = ($urandom_range(0, 399) == 0);
            step(1);
        end
        RESET = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
